// File: rtl/md5_pkg.sv
// Shared types for the MD5 accelerator: block type, read-FSM states and the
// read reorder-buffer slot layout.
package md5_pkg;

    localparam int MD5_BLOCK_W         = 512;
    localparam int MD5_MAX_OUTSTANDING = 8;

    typedef logic [MD5_BLOCK_W-1:0] t_block;

    typedef logic [$clog2(MD5_MAX_OUTSTANDING)-1:0] t_rd_tag;

    typedef enum logic [1:0] {
        S_RD_IDLE   = 2'd0,
        S_RD_FETCH  = 2'd1,
        S_RD_FINISH = 2'd2
    } t_rd_state;

    typedef struct packed {
        logic   valid;
        logic   pending;
        t_block data;
    } t_rd_slot;

endpackage

// File: rtl/md5_rd_rob.sv
// Read reorder buffer: one slot per tag, with pending (request in flight) and
// valid (data landed, not yet consumed) bitmaps.
module md5_rd_rob
    import md5_pkg::*;
#(
    parameter int DEPTH = MD5_MAX_OUTSTANDING,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             set_pend,
    input  logic [TAG_W-1:0] set_tag,
    input  logic             wr_en,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             wr_keep,
    input  t_block           wr_data,
    input  logic             pop,
    input  logic [TAG_W-1:0] head,
    output t_rd_slot         head_slot,
    output logic [DEPTH-1:0] pend_map
);

    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] set_mask;
    logic [DEPTH-1:0] wr_mask;
    logic [DEPTH-1:0] keep_mask;
    logic [DEPTH-1:0] pop_mask;
    t_block           mem [DEPTH];

    assign set_mask  = set_pend ? (DEPTH'(1) << set_tag) : '0;
    assign wr_mask   = wr_en    ? (DEPTH'(1) << wr_tag)  : '0;
    assign keep_mask = wr_keep  ? wr_mask : '0;
    assign pop_mask  = pop      ? (DEPTH'(1) << head)    : '0;

    // A landing response and a pop never hit the same slot, so the masks compose freely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q  <= '0;
            valid_q <= '0;
        end else if (clr) begin
            pend_q  <= '0;
            valid_q <= '0;
        end else begin
            pend_q  <= (pend_q & ~wr_mask) | set_mask;
            valid_q <= (valid_q & ~pop_mask) | keep_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && wr_keep) begin
            mem[wr_tag] <= wr_data;
        end
    end

    assign head_slot = '{valid: valid_q[head], pending: pend_q[head], data: mem[head]};
    assign pend_map  = pend_q;

endmodule

// File: rtl/md5_rd_scheduler.sv
// Read-side controller: issues bounded outstanding CCI-P c0 reads for the host
// buffer and hands the lines to the MD5 core strictly in address order.
module md5_rd_scheduler
    import md5_pkg::*;
#(
    parameter int MAX_OUTSTANDING = MD5_MAX_OUTSTANDING,
    parameter int TAG_W           = $clog2(MAX_OUTSTANDING),
    parameter int CL_ADDR_W       = 42
) (
    input  logic                 clk,
    input  logic                 SoftReset,
    input  logic                 start,
    input  logic                 stop,
    input  logic [63:0]          buf_addr,
    input  logic [31:0]          buf_lines,
    output logic                 rd_req_valid,
    output logic [CL_ADDR_W-1:0] rd_req_addr,
    output logic [TAG_W-1:0]     rd_req_tag,
    input  logic                 c0_almost_full,
    input  logic                 rd_rsp_valid,
    input  logic [TAG_W-1:0]     rd_rsp_tag,
    input  t_block               rd_rsp_data,
    output logic                 blk_valid,
    output t_block               blk_data,
    output logic                 blk_last,
    input  logic                 blk_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic                 tag_err
);

    t_rd_state                state_q, state_d;
    logic [31:0]              issued_q, popped_q, lines_q;
    logic [CL_ADDR_W-1:0]     base_q;
    logic                     stop_q;
    logic                     tag_err_q;
    logic                     req_valid_q;
    logic [CL_ADDR_W-1:0]     req_addr_q;
    logic [TAG_W-1:0]         req_tag_q;

    logic                     start_go;
    logic [31:0]              in_flight;
    logic                     fetch_issue;
    logic                     idle_issue;
    logic                     issue;
    logic [CL_ADDR_W-1:0]     issue_addr;
    logic [TAG_W-1:0]         issue_tag;
    logic                     rsp_live;
    logic                     rsp_hit;
    logic                     rsp_miss;
    logic                     pop;
    logic                     last_pop;
    logic                     pend_drained;
    logic [MAX_OUTSTANDING-1:0] rsp_mask;
    logic [MAX_OUTSTANDING-1:0] pend_map;
    t_rd_slot                 head_slot;
    logic                     unused_ok;

    assign unused_ok = ^{buf_addr[63:CL_ADDR_W+6], buf_addr[5:0], head_slot.pending};

    assign start_go  = (state_q == S_RD_IDLE) && start;
    assign in_flight = issued_q - popped_q;

    // A stop arriving this cycle already blocks issue; the latched copy takes over next cycle.
    assign fetch_issue = (state_q == S_RD_FETCH) && (issued_q < lines_q) && !c0_almost_full &&
                         (in_flight < 32'(MAX_OUTSTANDING)) && !stop_q && !stop;
    assign idle_issue  = start_go && (buf_lines != 32'd0) && !c0_almost_full;
    assign issue       = fetch_issue || idle_issue;
    assign issue_addr  = start_go ? buf_addr[CL_ADDR_W+5:6] : base_q + CL_ADDR_W'(issued_q);
    assign issue_tag   = start_go ? '0 : issued_q[TAG_W-1:0];

    assign rsp_live = rd_rsp_valid && (state_q != S_RD_IDLE);
    assign rsp_hit  = rsp_live && pend_map[rd_rsp_tag];
    assign rsp_miss = rsp_live && !pend_map[rd_rsp_tag];
    assign rsp_mask = rsp_hit ? (MAX_OUTSTANDING'(1) << rd_rsp_tag) : '0;

    assign pend_drained = (pend_map & ~rsp_mask) == '0;

    assign blk_valid = (state_q == S_RD_FETCH) && !stop_q && head_slot.valid;
    assign blk_data  = head_slot.data;
    assign blk_last  = blk_valid && (popped_q == lines_q - 32'd1);
    assign pop       = blk_valid && blk_ready;
    assign last_pop  = pop && (popped_q + 32'd1 == lines_q);

    md5_rd_rob #(
        .DEPTH (MAX_OUTSTANDING),
        .TAG_W (TAG_W)
    ) u_rob (
        .clk       (clk),
        .rst       (SoftReset),
        .clr       (state_q == S_RD_FINISH),
        .set_pend  (issue),
        .set_tag   (issue_tag),
        .wr_en     (rsp_hit),
        .wr_tag    (rd_rsp_tag),
        .wr_keep   (!stop_q),
        .wr_data   (rd_rsp_data),
        .pop       (pop),
        .head      (popped_q[TAG_W-1:0]),
        .head_slot (head_slot),
        .pend_map  (pend_map)
    );

    // Finish decisions look ahead at this cycle's pop/response so done lands one cycle later.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RD_IDLE: begin
                if (start) begin
                    state_d = (buf_lines == 32'd0) ? S_RD_FINISH : S_RD_FETCH;
                end
            end
            S_RD_FETCH: begin
                if (stop_q) begin
                    if (pend_drained) begin
                        state_d = S_RD_FINISH;
                    end
                end else if (last_pop || (popped_q == lines_q)) begin
                    state_d = S_RD_FINISH;
                end
            end
            S_RD_FINISH: state_d = S_RD_IDLE;
            default:     state_d = S_RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge SoftReset) begin
        if (SoftReset) begin
            state_q     <= S_RD_IDLE;
            issued_q    <= '0;
            popped_q    <= '0;
            lines_q     <= '0;
            base_q      <= '0;
            stop_q      <= 1'b0;
            tag_err_q   <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= issue;
            if (issue) begin
                req_addr_q <= issue_addr;
                req_tag_q  <= issue_tag;
            end
            if (start_go) begin
                base_q   <= buf_addr[CL_ADDR_W+5:6];
                lines_q  <= buf_lines;
                popped_q <= '0;
                issued_q <= idle_issue ? 32'd1 : 32'd0;
                stop_q   <= 1'b0;
            end else begin
                if (issue) begin
                    issued_q <= issued_q + 32'd1;
                end
                if (pop) begin
                    popped_q <= popped_q + 32'd1;
                end
                if (state_q == S_RD_FINISH) begin
                    stop_q <= 1'b0;
                end else if ((state_q == S_RD_FETCH) && stop && (state_d == S_RD_FETCH)) begin
                    stop_q <= 1'b1;
                end
            end
            if (rsp_miss) begin
                tag_err_q <= 1'b1;
            end
        end
    end

    assign rd_req_valid = req_valid_q;
    assign rd_req_addr  = req_addr_q;
    assign rd_req_tag   = req_tag_q;
    assign busy         = (state_q != S_RD_IDLE);
    assign done         = (state_q == S_RD_FINISH);
    assign aborted      = (state_q == S_RD_FINISH) && stop_q;
    assign tag_err      = tag_err_q;

endmodule

// File: tb/tb_md5_rd_scheduler.sv
// Scoreboard bench for md5_rd_scheduler: stimulus pushes expected requests,
// blocks and completions; a negedge monitor pops and compares them.
module tb_md5_rd_scheduler;
    import md5_pkg::*;

    localparam int MO = 8;
    localparam int TW = 3;
    localparam int AW = 42;

    logic          clk = 1'b0;
    logic          SoftReset;
    logic          start, stop;
    logic [63:0]   buf_addr;
    logic [31:0]   buf_lines;
    logic          rd_req_valid;
    logic [AW-1:0] rd_req_addr;
    logic [TW-1:0] rd_req_tag;
    logic          c0_almost_full;
    logic          rd_rsp_valid;
    logic [TW-1:0] rd_rsp_tag;
    t_block        rd_rsp_data;
    logic          blk_valid;
    t_block        blk_data;
    logic          blk_last;
    logic          blk_ready;
    logic          busy, done, aborted, tag_err;

    md5_rd_scheduler #(.MAX_OUTSTANDING(MO), .TAG_W(TW), .CL_ADDR_W(AW)) dut (
        .clk(clk), .SoftReset(SoftReset), .start(start), .stop(stop),
        .buf_addr(buf_addr), .buf_lines(buf_lines),
        .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_tag(rd_req_tag),
        .c0_almost_full(c0_almost_full),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_tag(rd_rsp_tag), .rd_rsp_data(rd_rsp_data),
        .blk_valid(blk_valid), .blk_data(blk_data), .blk_last(blk_last), .blk_ready(blk_ready),
        .busy(busy), .done(done), .aborted(aborted), .tag_err(tag_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct { logic [AW-1:0] addr; logic [TW-1:0] tag; } req_t;
    typedef struct { t_block data; logic last; } blk_t;

    req_t exp_req[$];
    blk_t exp_blk[$];
    bit   exp_done[$];

    int checks = 0, failures = 0;
    int req_seen = 0;
    int req_cyc[$];
    int last_pop_cyc = 0, done_cyc = 0, done_cnt = 0, blk_rise_cyc = -1;
    bit hold_chk_en = 1'b1;
    logic af_prev = 1'b0, bv_prev = 1'b0, br_prev = 1'b0;
    t_block bd_prev;

    function automatic t_block rsp_data(input logic [AW-1:0] a);
        t_block d;
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = a[31:0] ^ (32'h9E37_79B9 * (k + 1));
        return d;
    endfunction

    always @(negedge clk) begin : monitor
        req_t e;
        blk_t b;
        bit   ea;
        if (!SoftReset) begin
            if (rd_req_valid) begin
                req_seen++;
                req_cyc.push_back(cyc);
                checks++;
                if (exp_req.size() == 0) begin
                    failures++;
                    $display("FAIL req_unexpected got addr=%h tag=%0d required none", rd_req_addr, rd_req_tag);
                end else begin
                    e = exp_req.pop_front();
                    if (rd_req_addr !== e.addr || rd_req_tag !== e.tag) begin
                        failures++;
                        $display("FAIL req_fields got addr=%h tag=%0d required addr=%h tag=%0d",
                                 rd_req_addr, rd_req_tag, e.addr, e.tag);
                    end
                end
                checks++;
                if (af_prev) begin
                    failures++;
                    $display("FAIL req_during_af got request after almost_full cycle required none");
                end
            end
            af_prev = c0_almost_full;
            if (hold_chk_en && bv_prev && !br_prev) begin
                checks++;
                if (!blk_valid || blk_data !== bd_prev) begin
                    failures++;
                    $display("FAIL blk_hold got valid=%0d data_changed=%0d required valid=1 data_changed=0",
                             blk_valid, blk_data !== bd_prev);
                end
            end
            if (blk_valid && !bv_prev && blk_rise_cyc < 0) blk_rise_cyc = cyc;
            if (blk_valid && blk_ready) begin
                last_pop_cyc = cyc;
                checks++;
                if (exp_blk.size() == 0) begin
                    failures++;
                    $display("FAIL blk_unexpected got block last=%0d required none", blk_last);
                end else begin
                    b = exp_blk.pop_front();
                    if (blk_data !== b.data || blk_last !== b.last) begin
                        failures++;
                        $display("FAIL blk_fields got data[31:0]=%h last=%0d required data[31:0]=%h last=%0d",
                                 blk_data[31:0], blk_last, b.data[31:0], b.last);
                    end
                end
            end
            bv_prev = blk_valid;
            br_prev = blk_ready;
            bd_prev = blk_data;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                checks++;
                if (exp_done.size() == 0) begin
                    failures++;
                    $display("FAIL done_unexpected got done aborted=%0d required none", aborted);
                end else begin
                    ea = exp_done.pop_front();
                    if (aborted !== ea) begin
                        failures++;
                        $display("FAIL done_aborted got %0d required %0d", aborted, ea);
                    end
                end
            end
            if (aborted) begin
                checks++;
                if (!done) begin
                    failures++;
                    $display("FAIL aborted_without_done got done=0 required 1");
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got %0h required %0h", nm, act, req);
        end
    endtask

    task automatic pulse_start(input logic [63:0] a, input logic [31:0] n, output int sc);
        buf_addr = a; buf_lines = n; start = 1'b1; sc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic send_rsp(input logic [TW-1:0] t, input t_block d, output int rc);
        rd_rsp_valid = 1'b1; rd_rsp_tag = t; rd_rsp_data = d; rc = cyc;
        tick();
        rd_rsp_valid = 1'b0;
    endtask

    task automatic send_line(input int i, input logic [AW-1:0] base, output int rc);
        send_rsp(TW'(i % MO), rsp_data(base + AW'(i)), rc);
    endtask

    task automatic wait_reqs(input int n, input int budget);
        int k = 0;
        while (req_seen < n && k < budget) begin tick(); k++; end
        check("wait_reqs_timeout", 64'(req_seen >= n), 64'd1);
    endtask

    task automatic wait_done(input int n, input int budget);
        int k = 0;
        while (done_cnt < n && k < budget) begin tick(); k++; end
        check("wait_done_timeout", 64'(done_cnt >= n), 64'd1);
    endtask

    task automatic expect_run(input logic [AW-1:0] base, input int lines, input int nreq, input int nblk);
        for (int i = 0; i < nreq; i++) exp_req.push_back('{addr: base + AW'(i), tag: TW'(i % MO)});
        for (int i = 0; i < nblk; i++) exp_blk.push_back('{data: rsp_data(base + AW'(i)), last: (i == lines - 1)});
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got no completion required finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int sc, rc, rc0, rb, d0, p0;
        logic [AW-1:0] base;
        SoftReset = 1'b1; start = 1'b0; stop = 1'b0; buf_addr = '0; buf_lines = '0;
        c0_almost_full = 1'b0; rd_rsp_valid = 1'b0; rd_rsp_tag = '0; rd_rsp_data = '0; blk_ready = 1'b0;
        tick(3);
        check("reset_outputs", 64'({rd_req_valid, blk_valid, blk_last, busy, done, aborted, tag_err}), 64'd0);
        check("reset_req_addr", 64'(rd_req_addr), 64'd0);
        SoftReset = 1'b0;
        tick(2);
        check("post_reset_outputs", 64'({rd_req_valid, blk_valid, blk_last, busy, done, aborted, tag_err}), 64'd0);

        // in-order, four lines
        base = 42'h40; rb = req_seen; d0 = done_cnt; blk_ready = 1'b1;
        expect_run(base, 4, 4, 4); exp_done.push_back(1'b0);
        pulse_start(64'h1000, 32'd4, sc);
        check("busy_running", 64'(busy), 64'd1);
        for (int i = 0; i < 4; i++) begin wait_reqs(rb + i + 1, 20); send_line(i, base, rc); end
        check("first_req_cycle", 64'(req_cyc[rb]), 64'(sc + 1));
        wait_done(d0 + 1, 50);
        check("done_after_last_pop", 64'(done_cyc), 64'(last_pop_cyc + 1));
        tick();
        check("busy_idle", 64'(busy), 64'd0);

        // outstanding limit
        base = 42'h80; rb = req_seen; d0 = done_cnt;
        expect_run(base, 20, 20, 20); exp_done.push_back(1'b0);
        pulse_start(64'h2000, 32'd20, sc);
        tick(20);
        check("stall_at_limit", 64'(req_seen - rb), 64'd8);
        send_line(0, base, rc);
        wait_reqs(rb + 9, 10);
        p0 = last_pop_cyc;
        check("req9_after_pop", 64'((req_cyc[rb + 8] - p0 >= 1) && (req_cyc[rb + 8] - p0 <= 2)), 64'd1);
        for (int i = 1; i < 20; i++) begin wait_reqs(rb + i + 1, 50); send_line(i, base, rc); end
        wait_done(d0 + 1, 100);

        // out-of-order responses 3,1,0,2
        base = 42'h1000; rb = req_seen; d0 = done_cnt;
        expect_run(base, 4, 4, 4); exp_done.push_back(1'b0);
        pulse_start(64'h40000, 32'd4, sc);
        wait_reqs(rb + 4, 20);
        blk_rise_cyc = -1;
        send_line(3, base, rc);
        send_line(1, base, rc);
        send_line(0, base, rc0);
        send_line(2, base, rc);
        wait_done(d0 + 1, 50);
        check("blk_rise_after_tag0", 64'(blk_rise_cyc), 64'(rc0 + 1));

        // almost-full window and random backpressure
        base = 42'h4000; rb = req_seen; d0 = done_cnt;
        expect_run(base, 16, 16, 16); exp_done.push_back(1'b0);
        pulse_start(64'h100000, 32'd16, sc);
        fork
            begin
                int rcl;
                for (int i = 0; i < 16; i++) begin wait_reqs(rb + i + 1, 400); send_line(i, base, rcl); end
            end
            begin
                wait_reqs(rb + 3, 50);
                c0_almost_full = 1'b1;
                tick(10);
                c0_almost_full = 1'b0;
            end
            begin
                int k = 0;
                while (done_cnt == d0 && k < 1000) begin blk_ready = 1'($urandom_range(0, 1)); tick(); k++; end
                blk_ready = 1'b1;
            end
        join
        check("bp_run_done", 64'(done_cnt), 64'(d0 + 1));

        // stop with three responses outstanding
        hold_chk_en = 1'b0;
        base = 42'h2000; rb = req_seen; d0 = done_cnt;
        expect_run(base, 16, 5, 0); exp_done.push_back(1'b1);
        c0_almost_full = 1'b1; blk_ready = 1'b0;
        pulse_start(64'h80000, 32'd16, sc);
        tick(2);
        c0_almost_full = 1'b0;
        tick(5);
        c0_almost_full = 1'b1;
        tick(3);
        check("five_issued", 64'(req_seen - rb), 64'd5);
        send_line(0, base, rc);
        send_line(1, base, rc);
        tick(2);
        check("head_valid_before_stop", 64'(blk_valid), 64'd1);
        pulse_stop();
        c0_almost_full = 1'b0; blk_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("blk_valid_after_stop", 64'(blk_valid), 64'd0);
            tick();
        end
        send_line(3, base, rc);
        send_line(2, base, rc);
        tick(2);
        check("no_early_abort", 64'(done_cnt), 64'(d0));
        send_line(4, base, rc);
        wait_done(d0 + 1, 10);
        check("abort_after_last_rsp", 64'(done_cyc), 64'(rc + 1));
        tick(3);
        check("no_req_after_stop", 64'(req_seen - rb), 64'd5);
        hold_chk_en = 1'b1;

        // response while idle, zero-length buffer, bad tag
        send_rsp(TW'(2), {16{32'hDEAD_BEEF}}, rc);
        tick();
        check("rsp_idle_silent", 64'(tag_err), 64'd0);
        rb = req_seen; d0 = done_cnt;
        exp_done.push_back(1'b0);
        pulse_start(64'h3000, 32'd0, sc);
        wait_done(d0 + 1, 10);
        check("zero_lines_done", 64'((done_cyc - sc >= 1) && (done_cyc - sc <= 2)), 64'd1);
        tick(3);
        check("zero_lines_no_req", 64'(req_seen - rb), 64'd0);

        d0 = done_cnt;
        c0_almost_full = 1'b1;
        exp_done.push_back(1'b1);
        pulse_start(64'h5000, 32'd2, sc);
        tick();
        send_rsp(TW'(5), {16{32'h0BAD_F00D}}, rc);
        tick();
        check("tag_err_set", 64'(tag_err), 64'd1);
        pulse_stop();
        wait_done(d0 + 1, 10);
        tick(2);
        check("tag_err_sticky", 64'(tag_err), 64'd1);
        c0_almost_full = 1'b0;

        check("exp_req_drained", 64'(exp_req.size()), 64'd0);
        check("exp_blk_drained", 64'(exp_blk.size()), 64'd0);
        check("exp_done_drained", 64'(exp_done.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
